// File: rtl/vip_target_bbox_detect_if.sv
// Pixel-stream and target-position bundle between the binarisation stage,
// the bounding-box detector and the overlay stage.
`timescale 1ns / 1ps

interface vip_target_bbox_detect_if;
  logic        per_frame_vsync;
  logic        per_frame_href;
  logic        per_frame_clken;
  logic        per_img_bit;
  logic [42:0] target_pos_out;
  logic        target_pos_valid;

  // Upstream side: drives the mask stream, observes the published box.
  modport master (
    output per_frame_vsync,
    output per_frame_href,
    output per_frame_clken,
    output per_img_bit,
    input  target_pos_out,
    input  target_pos_valid
  );

  // Detector side.
  modport slave (
    input  per_frame_vsync,
    input  per_frame_href,
    input  per_frame_clken,
    input  per_img_bit,
    output target_pos_out,
    output target_pos_valid
  );
endinterface

// File: rtl/vip_target_bbox_detect.sv
// Bounding box of foreground pixels in a binary motion mask, published once per
// frame as {flag, ymax, xmax, ymin, xmin}. Optional coasting: BBOX_HOLD_EN.
`timescale 1ns / 1ps

module vip_target_bbox_detect #(
  parameter int IMG_HDISP   = 1280,
  parameter int IMG_VDISP   = 720,
  parameter int MIN_PIXELS  = 64,
  parameter int HOLD_FRAMES = 8
) (
  input logic                     clk,
  input logic                     rst,
  vip_target_bbox_detect_if.slave bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam logic [10:0] X_LAST  = 11'(IMG_HDISP - 1);
  localparam logic [9:0]  Y_LAST  = 10'(IMG_VDISP - 1);
  localparam logic [9:0]  Y_LIM   = 10'(IMG_VDISP);
  localparam logic [19:0] MIN_CNT = 20'(MIN_PIXELS);

  // Output fields are fixed at 11/10 bits for the overlay stage.
  generate
    if (IMG_HDISP < 1 || IMG_HDISP > 2048 || IMG_VDISP < 1 || IMG_VDISP > 1023 ||
        MIN_PIXELS < 0 || MIN_PIXELS > 1048575 ||
        HOLD_FRAMES < 0 || HOLD_FRAMES > 255) begin : g_bad_cfg
      $error("vip_target_bbox_detect: parameter out of range");
    end
  endgenerate

  logic vsync, href, clken, pix;
  assign vsync = bus.per_frame_vsync;
  assign href  = bus.per_frame_href;
  assign clken = bus.per_frame_clken;
  assign pix   = bus.per_img_bit;

  logic        vs_d, hs_d;
  logic        frame_start, frame_end, line_end, accept;
  logic [1:0]  state;
  logic [10:0] x_cnt;
  logic [9:0]  y_cnt;
  logic        line_has_pix;
  logic [10:0] xmin, xmax;
  logic [9:0]  ymin, ymax;
  logic [19:0] pix_cnt;
  logic        pass;
  logic [41:0] box;
  logic [42:0] result;
  logic [42:0] pos_q;
  logic        valid_q;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // always_ff samples the pre-edge values regardless of block ordering.
  // NOTE: vs_d resets high so a reset released mid-frame sees no rising edge
  // and waits for the next complete frame instead of reporting a partial one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_d <= 1'b1;
      hs_d <= 1'b0;
    end else begin
      vs_d <= vsync;
      hs_d <= href;
    end
  end

  assign frame_start = vsync & ~vs_d;
  assign frame_end   = ~vsync & vs_d;
  assign line_end    = ~href & hs_d;
  assign accept      = (state == S_ACTIVE) & vsync & href & clken & (y_cnt < Y_LIM);

  // A frame end while idle falls through the default arm and is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else if (frame_start) begin
      state <= S_ACTIVE;
    end else begin
      case (state)
        S_ACTIVE: if (frame_end) state <= S_DONE;
        S_DONE:   state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  // Pixel coordinates; a line only advances y if it delivered a pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_cnt        <= '0;
      y_cnt        <= '0;
      line_has_pix <= 1'b0;
    end else if (frame_start) begin
      x_cnt        <= '0;
      y_cnt        <= '0;
      line_has_pix <= 1'b0;
    end else if (line_end) begin
      x_cnt        <= '0;
      line_has_pix <= 1'b0;
      if (line_has_pix) y_cnt <= y_cnt + 10'd1;
    end else if (accept) begin
      line_has_pix <= 1'b1;
      if (x_cnt < X_LAST) x_cnt <= x_cnt + 11'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xmin    <= '0;
      xmax    <= '0;
      ymin    <= '0;
      ymax    <= '0;
      pix_cnt <= '0;
    end else if (frame_start) begin
      xmin    <= X_LAST;
      ymin    <= Y_LAST;
      xmax    <= '0;
      ymax    <= '0;
      pix_cnt <= '0;
    end else if (accept && pix) begin
      if (x_cnt < xmin) xmin <= x_cnt;
      if (x_cnt > xmax) xmax <= x_cnt;
      if (y_cnt < ymin) ymin <= y_cnt;
      if (y_cnt > ymax) ymax <= y_cnt;
      if (pix_cnt != 20'hF_FFFF) pix_cnt <= pix_cnt + 20'd1;
    end
  end

  assign pass = (pix_cnt >= MIN_CNT);
  assign box  = {ymax, xmax, ymin, xmin};

`ifdef BBOX_HOLD_EN
  localparam int HOLD_W = (HOLD_FRAMES > 15) ? 8 : 4;
  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(HOLD_FRAMES);

  logic [HOLD_W-1:0] hold_cnt;
  logic [41:0]       last_box;
  logic              have_box;
  logic              can_hold;

  assign can_hold = have_box && (hold_cnt < HOLD_LIM);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    result = '0;
    if (pass)          result = {1'b1, box};
    else if (can_hold) result = {1'b1, last_box};
  end

  // Coasting state: the last passing box and how many failing frames reused it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt <= '0;
      last_box <= '0;
      have_box <= 1'b0;
    end else if (state == S_DONE) begin
      if (pass) begin
        hold_cnt <= '0;
        last_box <= box;
        have_box <= 1'b1;
      end else if (can_hold) begin
        hold_cnt <= hold_cnt + HOLD_W'(1);
      end
    end
  end
`else
  assign result = pass ? {1'b1, box} : 43'd0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= (state == S_DONE);
      if (state == S_DONE) pos_q <= result;
    end
  end

  assign bus.target_pos_out   = pos_q;
  assign bus.target_pos_valid = valid_q;

endmodule

// File: tb/tb_vip_target_bbox_detect.sv
// Self-checking bench for vip_target_bbox_detect: directed frames plus random
// boxes, checked against a coordinate-set model of the frame.
`timescale 1ns / 1ps

module tb_vip_target_bbox_detect;
  localparam int H     = 1280;
  localparam int V     = 720;
  localparam int MINP  = 64;
  localparam int HOLDF = 8;
`ifdef BBOX_HOLD_EN
  localparam bit HOLD_ON = 1'b1;
`else
  localparam bit HOLD_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vip_target_bbox_detect_if bus_if ();

  vip_target_bbox_detect #(
    .IMG_HDISP  (H),
    .IMG_VDISP  (V),
    .MIN_PIXELS (MINP),
    .HOLD_FRAMES(HOLDF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  int errors    = 0;
  int checks    = 0;
  int pulse_cnt = 0;

  // Frame description: line lengths (raw strobes per line) and foreground set.
  int line_len[$];
  bit fg[int];

  // Reference-model coasting memory.
  bit          m_have;
  logic [41:0] m_last;
  int          m_hold;

  always @(negedge clk) if (bus_if.target_pos_valid === 1'b1) pulse_cnt++;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  function automatic int key(input int l, input int i);
    return l * 4096 + i;
  endfunction

  task automatic clear_frame();
    line_len.delete();
    fg.delete();
  endtask

  task automatic set_px(input int l, input int i);
    fg[key(l, i)] = 1'b1;
  endtask

  // Box over every foreground strobe that lands inside the image; strobes past
  // the line width take the last column.
  task automatic model(output logic [42:0] exp);
    int cnt, xmn, xmx, ymn, ymx, x;
    logic [41:0] b;
    bit pass;
    cnt = 0; xmn = H - 1; xmx = 0; ymn = V - 1; ymx = 0;
    for (int l = 0; l < line_len.size() && l < V; l++)
      for (int i = 0; i < line_len[l]; i++)
        if (fg.exists(key(l, i))) begin
          x = (i > H - 1) ? H - 1 : i;
          if (x < xmn) xmn = x;
          if (x > xmx) xmx = x;
          if (l < ymn) ymn = l;
          if (l > ymx) ymx = l;
          cnt++;
        end
    pass = (cnt >= MINP);
    b = {10'(ymx), 11'(xmx), 10'(ymn), 11'(xmn)};
    exp = 43'd0;
    if (pass) begin
      exp = {1'b1, b};
      m_have = 1'b1;
      m_last = b;
      m_hold = 0;
    end else if (HOLD_ON && m_have && m_hold < HOLDF) begin
      exp = {1'b1, m_last};
      m_hold++;
    end
  endtask

  task automatic send_lines(input int from, input int to);
    int i;
    for (int l = from; l < to; l++) begin
      bus_if.per_frame_href = 1'b1;
      i = 0;
      while (i < line_len[l]) begin
        if ($urandom_range(3) == 0) begin
          bus_if.per_frame_clken = 1'b0;
          bus_if.per_img_bit     = 1'($urandom_range(1));
        end else begin
          bus_if.per_frame_clken = 1'b1;
          bus_if.per_img_bit     = fg.exists(key(l, i)) ? 1'b1 : 1'b0;
          i++;
        end
        step();
      end
      bus_if.per_frame_href  = 1'b0;
      bus_if.per_frame_clken = 1'b0;
      bus_if.per_img_bit     = 1'b0;
      repeat ($urandom_range(3, 1)) step();
    end
  endtask

  task automatic start_frame();
    bus_if.per_frame_vsync = 1'b1;
    repeat (2) step();
  endtask

  // Drops vsync together with a foreground strobe that must be ignored, then
  // records the cycle (counted from the drop) at which the pulse appears.
  task automatic finish_frame(output int first_at);
    bus_if.per_frame_vsync = 1'b0;
    bus_if.per_frame_href  = 1'b1;
    bus_if.per_frame_clken = 1'b1;
    bus_if.per_img_bit     = 1'b1;
    first_at = 0;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 1) begin
        bus_if.per_frame_href  = 1'b0;
        bus_if.per_frame_clken = 1'b0;
        bus_if.per_img_bit     = 1'b0;
      end
      if (bus_if.target_pos_valid === 1'b1 && first_at == 0) first_at = k;
    end
    #1;
  endtask

  task automatic do_frame(input string tag, input bit use_lit, input logic [42:0] lit);
    logic [42:0] exp;
    int p0, first_at;
    model(exp);
    p0 = pulse_cnt;
    start_frame();
    send_lines(0, line_len.size());
    finish_frame(first_at);
    check({tag, " pulses"}, 64'(pulse_cnt - p0), 64'd1);
    check({tag, " latency"}, 64'(first_at), 64'd2);
    check({tag, " pos"}, 64'(bus_if.target_pos_out), 64'(exp));
    if (use_lit) check({tag, " pos_lit"}, 64'(bus_if.target_pos_out), 64'(lit));
  endtask

  logic [42:0] rect_lit;

  initial begin
    int p0, first_at, n, x0, w, y0, h, k, l;
    bus_if.per_frame_vsync = 1'b0;
    bus_if.per_frame_href  = 1'b0;
    bus_if.per_frame_clken = 1'b0;
    bus_if.per_img_bit     = 1'b0;
    m_have = 1'b0; m_last = '0; m_hold = 0;
    rect_lit = {1'b1, 10'd59, 11'd199, 10'd50, 11'd100};

    repeat (3) step();
    check("reset pos", 64'(bus_if.target_pos_out), 64'd0);
    check("reset valid", 64'(bus_if.target_pos_valid), 64'd0);
    rst = 1'b0;
    repeat (2) step();

    // All-zero frame.
    clear_frame();
    repeat (3) line_len.push_back(10);
    do_frame("empty", 1'b1, 43'd0);

    // 63 scattered ones, then the same plus one more.
    clear_frame();
    repeat (10) line_len.push_back(100);
    for (int j = 0; j < 63; j++) set_px(j % 10, (j * 7) % 100);
    do_frame("thresh63", 1'b1, 43'd0);
    line_len[2] = 150;
    set_px(2, 120);
    do_frame("thresh64", 1'b1, {1'b1, 10'd9, 11'd120, 10'd0, 11'd0});

    // Rectangle x=100..199, y=50..59.
    clear_frame();
    repeat (50) line_len.push_back($urandom_range(20, 1));
    repeat (10) line_len.push_back(200);
    for (int y = 50; y < 60; y++)
      for (int x = 100; x < 200; x++) set_px(y, x);
    do_frame("rect", 1'b1, rect_lit);

    // Corner pixels plus 62 interior ones.
    clear_frame();
    for (int y = 0; y < V; y++) line_len.push_back(1);
    line_len[0]   = 5;
    line_len[719] = H;
    set_px(0, 0);
    set_px(719, H - 1);
    for (int y = 100; y < 162; y++) begin
      line_len[y] = 60;
      set_px(y, 50);
    end
    do_frame("corner", 1'b1, {1'b1, 10'd719, 11'd1279, 10'd0, 11'd0});

    // 1290-strobe line: columns past 1279 collapse onto the last column.
    clear_frame();
    line_len.push_back(1290);
    line_len.push_back(3);
    for (int i = 1200; i < 1290; i++) set_px(0, i);
    do_frame("xsat", 1'b1, {1'b1, 10'd0, 11'd1279, 10'd0, 11'd1200});

    // Reset at line 300 of a frame that would otherwise pass.
    clear_frame();
    for (int y = 0; y < 400; y++) begin
      line_len.push_back($urandom_range(8, 1));
      set_px(y, 0);
    end
    p0 = pulse_cnt;
    start_frame();
    send_lines(0, 300);
    #2 rst = 1'b1;
    #2;
    check("midrst pos", 64'(bus_if.target_pos_out), 64'd0);
    check("midrst valid", 64'(bus_if.target_pos_valid), 64'd0);
    step();
    step();
    rst = 1'b0;
    m_have = 1'b0; m_hold = 0;
    step();
    send_lines(300, 400);
    finish_frame(first_at);
    check("aborted pulses", 64'(pulse_cnt - p0), 64'd0);
    check("aborted pos", 64'(bus_if.target_pos_out), 64'd0);

    // First complete frame after reset: box x 10..20, y 5..15.
    clear_frame();
    repeat (5) line_len.push_back($urandom_range(9, 1));
    repeat (11) line_len.push_back(21);
    repeat (3) line_len.push_back($urandom_range(9, 1));
    for (int y = 5; y <= 15; y++)
      for (int x = 10; x <= 20; x++) set_px(y, x);
    do_frame("after_rst", 1'b1, {1'b1, 10'd15, 11'd20, 10'd5, 11'd10});

    // Random rectangles plus scattered noise.
    for (int r = 0; r < 5; r++) begin
      clear_frame();
      n = $urandom_range(30, 5);
      for (int y = 0; y < n; y++) line_len.push_back($urandom_range(300, 1));
      x0 = $urandom_range(250, 0);
      w  = $urandom_range(40, 1);
      y0 = $urandom_range(n - 1, 0);
      h  = $urandom_range(n - y0, 1);
      for (int y = y0; y < y0 + h; y++) begin
        if (line_len[y] < x0 + w) line_len[y] = x0 + w + $urandom_range(10, 0);
        for (int x = x0; x < x0 + w; x++) set_px(y, x);
      end
      k = $urandom_range(20, 0);
      for (int j = 0; j < k; j++) begin
        l = $urandom_range(n - 1, 0);
        set_px(l, $urandom_range(line_len[l] - 1, 0));
      end
      do_frame($sformatf("rand%0d", r), 1'b0, 43'd0);
    end

    // One valid box, then nine empty frames (coasting when enabled).
    clear_frame();
    repeat (50) line_len.push_back($urandom_range(20, 1));
    repeat (10) line_len.push_back(200);
    for (int y = 50; y < 60; y++)
      for (int x = 100; x < 200; x++) set_px(y, x);
    do_frame("hold_box", 1'b1, rect_lit);
    for (int f = 1; f <= 9; f++) begin
      clear_frame();
      repeat (2) line_len.push_back(8);
      do_frame($sformatf("hold_empty%0d", f), 1'b1,
               (HOLD_ON && f <= HOLDF) ? rect_lit : 43'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
